// File: rtl/camera_pkg.sv
// Shared encodings for the camera configuration sequencer: FSM states,
// ROM control words and the SCCB write request record.
package camera_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        ISSUE,
        WAIT,
        DELAY,
        DONE
    } state_t;

    localparam logic [15:0] END_WORD   = 16'hFFFF;
    localparam logic [15:0] DELAY_WORD = 16'hFFF0;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] val;
    } sccb_req_t;

endpackage

// File: rtl/cfg_delay_timer.sv
// Down-counter for ROM delay entries: load arms DELAY_CYC cycles, count
// advances while in DELAY, expire flags the last counted cycle.
module cfg_delay_timer #(
    parameter int DELAY_CYC = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic count,
    output logic expire
);
    localparam int CW = (DELAY_CYC < 2) ? 1 : $clog2(DELAY_CYC + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (load)
            cnt <= CW'(DELAY_CYC);
        else if (count && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    // A zero-length delay still spends one cycle in DELAY.
    assign expire = count && (cnt <= CW'(1));

endmodule

// File: rtl/camera_cfg_seq.sv
// Walks a config ROM and issues SCCB register writes, delays and an end marker.
// Define CFG_RETRY_EN to reissue NACKed writes up to MAX_RETRY times.
module camera_cfg_seq
    import camera_pkg::*;
#(
    parameter int ROM_AW    = 8,
    parameter int DELAY_CYC = 500000,
    parameter int MAX_RETRY = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_rom,
    output logic              done_rom,
    output logic              cfg_err,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    input  logic              sccb_ready,
    output logic              sccb_start,
    output logic [7:0]        sccb_reg,
    output logic [7:0]        sccb_val,
    input  logic              sccb_done,
    input  logic              sccb_nack
);
    localparam logic [ROM_AW-1:0] LAST_ADDR = '1;

    state_t    state;
    sccb_req_t req;
    logic      tmr_load, tmr_count, tmr_expire;
    logic      entry_done, entry_fail;

`ifdef CFG_RETRY_EN
    localparam int RCW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    logic [RCW-1:0] retry_cnt;
    logic           retry_now;
`endif

    assign sccb_reg  = req.addr;
    assign sccb_val  = req.val;
    assign tmr_load  = (state == DECODE) && (rom_data == DELAY_WORD);
    assign tmr_count = (state == DELAY);

    cfg_delay_timer #(.DELAY_CYC(DELAY_CYC)) u_delay (
        .clk    (clk),
        .reset  (reset),
        .load   (tmr_load),
        .count  (tmr_count),
        .expire (tmr_expire)
    );

    // entry_done: current ROM entry is finished (write settled or delay elapsed).
    always_comb begin
        entry_done = 1'b0;
        entry_fail = 1'b0;
`ifdef CFG_RETRY_EN
        retry_now  = 1'b0;
`endif
        case (state)
            WAIT: if (sccb_done) begin
`ifdef CFG_RETRY_EN
                if (sccb_nack && retry_cnt < RCW'(MAX_RETRY)) begin
                    retry_now = 1'b1;
                end else begin
                    entry_done = 1'b1;
                    entry_fail = sccb_nack;
                end
`else
                entry_done = 1'b1;
                entry_fail = sccb_nack;
`endif
            end
            DELAY:   entry_done = tmr_expire;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            done_rom   <= 1'b0;
            cfg_err    <= 1'b0;
            rom_addr   <= '0;
            sccb_start <= 1'b0;
            req        <= '0;
`ifdef CFG_RETRY_EN
            retry_cnt  <= '0;
`endif
        end else begin
            sccb_start <= 1'b0;
            case (state)
                IDLE, DONE: if (load_rom) begin
                    done_rom <= 1'b0;
                    cfg_err  <= 1'b0;
                    rom_addr <= '0;
                    state    <= FETCH;
                end
                FETCH: state <= DECODE;
                DECODE: begin
                    if (rom_data == END_WORD) begin
                        done_rom <= 1'b1;
                        state    <= DONE;
                    end else if (rom_data == DELAY_WORD) begin
                        state <= DELAY;
                    end else begin
                        req   <= '{addr: rom_data[15:8], val: rom_data[7:0]};
                        state <= ISSUE;
                    end
                end
                // req stays frozen until the next DECODE, covering the whole transfer.
                ISSUE: if (sccb_ready) begin
                    sccb_start <= 1'b1;
                    state      <= WAIT;
                end
                WAIT, DELAY: ;
                default: state <= IDLE;
            endcase

            if (entry_done) begin
                if (entry_fail)
                    cfg_err <= 1'b1;
                // Running off the end of the ROM without an end marker is an error.
                if (rom_addr == LAST_ADDR) begin
                    cfg_err  <= 1'b1;
                    done_rom <= 1'b1;
                    state    <= DONE;
                end else begin
                    rom_addr <= rom_addr + 1'b1;
                    state    <= FETCH;
                end
            end

`ifdef CFG_RETRY_EN
            if (retry_now) begin
                retry_cnt <= retry_cnt + 1'b1;
                state     <= ISSUE;
            end
            if (state == DECODE || entry_done)
                retry_cnt <= '0;
`endif
        end
    end

endmodule
